// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns,
// segment bit order and the scan state encoding.
package seg7_pkg;

  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// BCD to active-high segment decoder; codes 10..15 produce an all-off pattern.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // pattern lookup
  always_comb begin
    o_seg = SEG_OFF;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with per-slot blanking, a
// double-buffered digit value and a single shared decoder.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  input  logic                  sel,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int                IW         = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [DIGITS-1:0] SEL_NONE   = {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0] SEL_ONE    = {{(DIGITS-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]     IDX_ZERO   = {IW{1'b0}};

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_index, w_index_nxt, w_first_idx, w_above_idx;
  logic                w_has_above, w_en_any, w_boundary, w_lz_off;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [4*DIGITS-1:0] r_shadow, r_display;
  logic                r_pending;
  logic [3:0]          w_digit_val;
  logic [6:0]          w_dec, w_seg_nxt, r_seg;
  logic [DIGITS-1:0]   w_sel_nxt, r_digit_sel;
  logic                r_frame_done;

  assign w_en_any    = (digit_en != SEL_NONE);
  assign w_digit_val = r_display[{r_index, 2'b00} +: 4];

  seg7_digit_decode u_decode (
    .i_bcd (w_digit_val),
    .o_seg (w_dec)
  );

  // lowest enabled digit, and the nearest enabled digit above the current one
  always_comb begin
    w_first_idx = IDX_ZERO;
    w_above_idx = IDX_ZERO;
    w_has_above = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (digit_en[i]) begin
        w_first_idx = IW'(i);
        if (IW'(i) > r_index) begin
          w_above_idx = IW'(i);
          w_has_above = 1'b1;
        end else begin
          w_has_above = w_has_above;
        end
      end else begin
        w_first_idx = w_first_idx;
      end
    end
  end

  // leading-zero suppression: current digit and every digit above it are zero
  always_comb begin
    w_lz_off = lz_blank && (r_index != IDX_ZERO);
    for (int i = 0; i < DIGITS; i++) begin
      if ((IW'(i) >= r_index) && (r_display[4*i +: 4] != 4'd0)) begin
        w_lz_off = 1'b0;
      end else begin
        w_lz_off = w_lz_off;
      end
    end
  end

  // scan sequencing: next state, slot counter and digit index
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_cnt_nxt   = r_cnt;
    w_boundary  = 1'b0;
    if (!w_en_any) begin
      w_state_nxt = ST_IDLE;
      w_index_nxt = IDX_ZERO;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_index_nxt = w_first_idx;
          w_cnt_nxt   = CNT_ZERO;
        end
        ST_BLANK: begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
          end else begin
            w_state_nxt = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = CNT_ZERO;
            w_index_nxt = w_has_above ? w_above_idx : w_first_idx;
            w_boundary  = !w_has_above;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_index_nxt = IDX_ZERO;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // pre-register output values; a dropped mask forces outputs off at once
  always_comb begin
    w_sel_nxt = SEL_NONE;
    w_seg_nxt = SEG_OFF;
    if ((r_state == ST_SHOW) && w_en_any) begin
      w_sel_nxt = SEL_ONE << r_index;
      w_seg_nxt = w_lz_off ? SEG_OFF : w_dec;
    end else begin
      w_sel_nxt = SEL_NONE;
      w_seg_nxt = SEG_OFF;
    end
  end

  // scan state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_index <= IDX_ZERO;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // double buffer: a load arriving on a boundary stays pending for the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= {(4*DIGITS){1'b0}};
      r_display <= {(4*DIGITS){1'b0}};
      r_pending <= 1'b0;
    end else begin
      if (w_boundary && r_pending) begin
        r_display <= r_shadow;
      end
      if (load) begin
        r_shadow  <= bcd_in;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= SEG_OFF;
      r_digit_sel  <= SEL_NONE;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_digit_sel  <= w_sel_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign seg        = r_seg ^ {7{sel}};
  assign digit_sel  = r_digit_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, 8-clock slots, 2-clock blanking):
// expected slot patterns are queued by the stimulus, popped by a monitor.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] OFF = 7'b0000000;

  typedef struct packed {
    logic [3:0] dsel;
    logic [6:0] dseg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'b0000;
  logic        lz_blank = 1'b0;
  logic        sel = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_done;

  exp_t q[$];
  logic [3:0] prev_sel = 4'b0000;
  int n_tests = 0;
  int n_fail = 0;

  seg7_scan_ctrl #(.DIGITS(4), .DWELL(8), .BLANK(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .load       (load),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .sel        (sel),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: each new slot (digit_sel rising from all-off) is compared against the queue head
  always @(negedge clk) begin
    if (!rst && digit_sel != 4'b0000 && prev_sel == 4'b0000 && q.size() > 0) begin
      check("slot_digit_sel", {28'd0, digit_sel}, {28'd0, q[0].dsel});
      check("slot_seg", {25'd0, seg}, {25'd0, q[0].dseg});
      void'(q.pop_front());
    end
    prev_sel <= digit_sel;
  end

  task automatic push(input logic [3:0] s, input logic [6:0] g);
    q.push_back('{dsel: s, dseg: g});
  endtask

  task automatic push4(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2, input logic [6:0] g3);
    push(4'b0001, g0);
    push(4'b0010, g1);
    push(4'b0100, g2);
    push(4'b1000, g3);
  endtask

  task automatic wait_fd();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_done && c < 200);
    if (!frame_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_frame_done: no pulse within %0d cycles", c);
    end
  endtask

  task automatic drain();
    int c = 0;
    while (q.size() > 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d slots still expected, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic measure_period(input int exp);
    int c = 0;
    wait_fd();
    do begin
      @(negedge clk);
      c++;
    end while (!frame_done && c < 100);
    check("frame_period", c, exp);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bcd_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int bad;
    // reset values
    repeat (3) @(negedge clk);
    check("rst_digit_sel", {28'd0, digit_sel}, 32'd0);
    check("rst_seg_sel0", {25'd0, seg}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    sel = 1'b1;
    #1;
    check("rst_seg_sel1", {25'd0, seg}, 32'h7F);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 1: all four digits, 0x1234, 32-clock frame
    digit_en = 4'b1111;
    repeat (2) @(negedge clk);
    pulse_load(16'h1234);
    wait_fd();
    push4(S4, S3, S2, S1);
    drain();
    measure_period(32);

    // 2: digits 0 and 2 only, 16-clock frame
    digit_en = 4'b0101;
    wait_fd();
    push(4'b0001, S4);
    push(4'b0100, S2);
    drain();
    measure_period(16);

    // 3: leading-zero blanking
    digit_en = 4'b1111;
    lz_blank = 1'b1;
    pulse_load(16'h0056);
    wait_fd();
    push4(S6, S5, OFF, OFF);
    drain();
    pulse_load(16'h0000);
    wait_fd();
    push4(S0, OFF, OFF, OFF);
    drain();

    // 4a: mid-frame load shows only after the boundary
    lz_blank = 1'b0;
    wait_fd();
    push4(S0, S0, S0, S0);
    repeat (12) @(negedge clk);
    pulse_load(16'h1111);
    wait_fd();
    push4(S1, S1, S1, S1);
    drain();

    // 4b: pending 0x2222, then 0x3333 loaded exactly on the boundary cycle
    wait_fd();
    push4(S1, S1, S1, S1);
    repeat (10) @(negedge clk);
    pulse_load(16'h2222);
    repeat (20) @(negedge clk);
    pulse_load(16'h3333);
    check("boundary_frame_done", {31'd0, frame_done}, 32'd1);
    push4(S2, S2, S2, S2);
    wait_fd();
    push4(S3, S3, S3, S3);
    drain();

    // 5: inverted polarity, code 0xA decodes to off
    sel = 1'b1;
    pulse_load(16'h1A34);
    wait_fd();
    push4(~S4, ~S3, 7'h7F, ~S1);
    drain();

    // 6: asynchronous reset mid-SHOW with a pending load
    pulse_load(16'h5555);
    rst = 1'b1;
    #1;
    check("async_rst_digit_sel", {28'd0, digit_sel}, 32'd0);
    check("async_rst_seg", {25'd0, seg}, 32'h7F);
    check("async_rst_frame_done", {31'd0, frame_done}, 32'd0);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fd();
    push4(S0, S0, S0, S0);
    drain();

    // mask dropped to zero: outputs off within one clock and stay off
    digit_en = 4'b0000;
    @(negedge clk);
    check("idle_digit_sel", {28'd0, digit_sel}, 32'd0);
    check("idle_seg", {25'd0, seg}, 32'd0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (digit_sel != 4'b0000 || seg != 7'b0000000 || frame_done) bad++;
    end
    check("idle_stays_off", bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
